// File: rtl/fifo_queue_flex_if.sv
// Valid/ack handshake bundle for fifo_queue_flex: producer side (request_in) and consumer side (request_out).
interface fifo_queue_flex_if #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 32
);
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in;
    logic                                  request_valid_in;
    logic                                  issue_ack_out;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out;
    logic                                  request_valid_out;
    logic                                  issue_ack_in;

    modport master (
        output request_in, request_valid_in, issue_ack_in,
        input  issue_ack_out, request_out, request_valid_out
    );

    modport slave (
        input  request_in, request_valid_in, issue_ack_in,
        output issue_ack_out, request_out, request_valid_out
    );
endinterface

// File: rtl/fifo_queue_flex.sv
// Arbitrary-depth FIFO with occupancy, almost-full/empty thresholds and synchronous flush.
// Optional combinational empty-queue bypass: define FIFO_QUEUE_FLEX_BYPASS_EN.
module fifo_queue_flex #(
    parameter int QUEUE_SIZE                 = 16,
    parameter int QUEUE_PTR_WIDTH_IN_BITS    = 4,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 32,
    parameter int ALMOST_FULL_THRESHOLD      = 12,
    parameter int ALMOST_EMPTY_THRESHOLD     = 2
) (
    input  logic                               clk_in,
    input  logic                               reset_in,
    input  logic                               flush_in,
    fifo_queue_flex_if.slave                   bus_if,
    output logic                               is_empty_out,
    output logic                               is_full_out,
    output logic                               almost_full_out,
    output logic                               almost_empty_out,
    output logic [QUEUE_PTR_WIDTH_IN_BITS:0]   occupancy_out
);
    localparam int PTR_W = QUEUE_PTR_WIDTH_IN_BITS;
    localparam int OCC_W = QUEUE_PTR_WIDTH_IN_BITS + 1;

    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] mem_q [QUEUE_SIZE];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             wr_fire, rd_fire, bypass_take;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        // Wrap at QUEUE_SIZE, not at 2^PTR_W, so non-power-of-two depths work.
        return (ptr == PTR_W'(QUEUE_SIZE - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign is_empty_out     = (occ_q == '0);
    assign is_full_out      = (occ_q == OCC_W'(QUEUE_SIZE));
    assign almost_full_out  = (occ_q >= OCC_W'(ALMOST_FULL_THRESHOLD));
    assign almost_empty_out = (occ_q <= OCC_W'(ALMOST_EMPTY_THRESHOLD));
    assign occupancy_out    = occ_q;

    assign bus_if.issue_ack_out = ~is_full_out & ~flush_in;

`ifdef FIFO_QUEUE_FLEX_BYPASS_EN
    logic bypass_active;
    assign bypass_active = is_empty_out & bus_if.request_valid_in & ~flush_in;
    assign bypass_take   = bypass_active & bus_if.issue_ack_in;
    assign bus_if.request_valid_out = ~is_empty_out | bypass_active;
    always_comb begin
        bus_if.request_out = '0;
        if (!is_empty_out)
            bus_if.request_out = mem_q[rd_ptr_q];
        else if (bypass_active)
            bus_if.request_out = bus_if.request_in;
    end
`else
    assign bypass_take = 1'b0;
    assign bus_if.request_valid_out = ~is_empty_out;
    assign bus_if.request_out       = is_empty_out ? '0 : mem_q[rd_ptr_q];
`endif

    // A bypassed word goes straight to the consumer and never touches storage.
    assign wr_fire = bus_if.request_valid_in & bus_if.issue_ack_out & ~bypass_take;
    assign rd_fire = ~is_empty_out & bus_if.issue_ack_in & ~flush_in;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (wr_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({wr_fire, rd_fire})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < QUEUE_SIZE; i++) mem_q[i] <= '0;
        end else if (wr_fire) begin
            mem_q[wr_ptr_q] <= bus_if.request_in;
        end
    end
endmodule
